regfile_mp: RTL and testbench

Parametrised multi-read-port register file that succeeds the fixed 32x32 two-read-port array used in the RISC-V datapath. It provides configurable width, depth and read-port count, write-to-read bypass, an optional hardwired-zero entry 0, and a sequential clear engine that zeroes the array after reset or on request. It sits between the decode stage, which drives the read addresses, and writeback, which drives the write port.

---
 rtl/regfile_mp.sv | 138 +++++++++++++
 tb/tb_regfile_mp.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - parametrised multi-read-port register file with bypass and clear engine
//
// Ports:
//   clk       : clock, all logic on posedge
//   rst       : synchronous active-high reset, starts a full array clear
//   wr_en     : write strobe
//   wr_addr   : write address
//   wr_data   : write data
//   rd_en     : read strobe shared by all read ports
//   rd_addr   : packed read addresses, port i at [i*ADDR_W +: ADDR_W]
//   rd_data   : packed registered read data, same packing as rd_addr
//   rd_valid  : high the cycle after an accepted read
//   clr_req   : single-cycle pulse requesting an array clear
//   busy      : clear engine active, reads and writes are refused

module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       rd_en,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic                       rd_valid,
  input  logic                       clr_req,
  output logic                       busy
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t                     state_q, state_d;
  logic [ADDR_W-1:0]          clr_cnt_q, clr_cnt_d;
  logic                       busy_q, busy_d;
  logic [NUM_RD*DATA_W-1:0]   rd_data_q, rd_data_d;
  logic                       rd_valid_q, rd_valid_d;

  logic [DATA_W-1:0]          mem_q [DEPTH];

  // Single array write port, shared between the clear engine and writeback.
  logic                       mem_we;
  logic [ADDR_W-1:0]          mem_waddr;
  logic [DATA_W-1:0]          mem_wdata;
  logic                       wr_acc;

  logic [ADDR_W-1:0]          rd_addr_a [NUM_RD];

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd_unpack
    assign rd_addr_a[g] = rd_addr[g*ADDR_W +: ADDR_W];
  end

  always_comb begin
    state_d    = state_q;
    clr_cnt_d  = clr_cnt_q;
    busy_d     = busy_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    mem_we     = 1'b0;
    mem_waddr  = wr_addr;
    mem_wdata  = wr_data;
    wr_acc     = 1'b0;

    if (state_q == CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = clr_cnt_q;
      mem_wdata = '0;
      clr_cnt_d = clr_cnt_q + 1'b1;
      // All-ones counter is the last entry; clr_req is ignored while here.
      if (&clr_cnt_q) begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    end else begin
      wr_acc = wr_en;
      // Writes to the hardwired-zero entry are dropped, not stored.
      mem_we = wr_en && !(ZERO_REG != 0 && wr_addr == '0);

      if (rd_en) begin
        rd_valid_d = 1'b1;
        for (int i = 0; i < NUM_RD; i++) begin
          if (ZERO_REG != 0 && rd_addr_a[i] == '0) begin
            rd_data_d[i*DATA_W +: DATA_W] = '0;
          end else if (BYPASS != 0 && wr_acc && wr_addr == rd_addr_a[i]) begin
            rd_data_d[i*DATA_W +: DATA_W] = wr_data;
          end else begin
            rd_data_d[i*DATA_W +: DATA_W] = mem_q[rd_addr_a[i]];
          end
        end
      end

      // A same-cycle write still lands; the clear wipes it afterwards.
      if (clr_req) begin
        state_d   = CLEAR;
        clr_cnt_d = '0;
        busy_d    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= CLEAR;
      clr_cnt_q  <= '0;
      busy_q     <= 1'b1;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
      busy_q     <= busy_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // Array has no reset of its own; the clear engine zeroes it after rst.
  always_ff @(posedge clk) begin
    if (!rst && mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - scoreboard bench for regfile_mp, default and wide/no-bypass variants

module tb_regfile_mp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: defaults (32x32, 2 ports, zero reg, bypass)
  logic         a_rst, a_wr_en, a_rd_en, a_clr_req, a_rd_valid, a_busy;
  logic [4:0]   a_wr_addr;
  logic [31:0]  a_wr_data;
  logic [9:0]   a_rd_addr;
  logic [63:0]  a_rd_data;

  // Instance B: 8x64, 4 ports, no zero reg, no bypass
  logic         b_rst, b_wr_en, b_rd_en, b_clr_req, b_rd_valid, b_busy;
  logic [2:0]   b_wr_addr;
  logic [63:0]  b_wr_data;
  logic [11:0]  b_rd_addr;
  logic [255:0] b_rd_data;

  regfile_mp dut_a (
    .clk(clk), .rst(a_rst), .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
    .rd_en(a_rd_en), .rd_addr(a_rd_addr), .rd_data(a_rd_data), .rd_valid(a_rd_valid),
    .clr_req(a_clr_req), .busy(a_busy)
  );

  regfile_mp #(.DATA_W(64), .ADDR_W(3), .NUM_RD(4), .ZERO_REG(0), .BYPASS(0)) dut_b (
    .clk(clk), .rst(b_rst), .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
    .rd_en(b_rd_en), .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_valid(b_rd_valid),
    .clr_req(b_clr_req), .busy(b_busy)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [63:0]  exp_a_q [$];
  logic [255:0] exp_b_q [$];
  logic [31:0]  model_a [32];
  logic [63:0]  model_b [8];

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock; outputs sampled 1ns after the edge and scored against the queues.
  task automatic step();
    @(posedge clk);
    #1;
    if (a_rd_valid) begin
      if (exp_a_q.size() == 0) check_eq("a_unexpected_valid", a_rd_valid, 1'b0);
      else check_eq("a_rd_data", a_rd_data, exp_a_q.pop_front());
    end
    if (b_rd_valid) begin
      if (exp_b_q.size() == 0) check_eq("b_unexpected_valid", b_rd_valid, 1'b0);
      else check_eq("b_rd_data", b_rd_data, exp_b_q.pop_front());
    end
  endtask

  function automatic logic [31:0] a_exp(input logic [4:0] r, input logic we,
                                        input logic [4:0] wa, input logic [31:0] wd);
    if (r == 5'd0) return 32'h0;
    if (we && wa == r) return wd;
    return model_a[r];
  endfunction

  // Caller guarantees instance A is idle (not clearing).
  task automatic a_cycle(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic re, input logic [4:0] r0, input logic [4:0] r1);
    if (re) exp_a_q.push_back({a_exp(r1, we, wa, wd), a_exp(r0, we, wa, wd)});
    if (we && wa != 5'd0) model_a[wa] = wd;
    a_wr_en = we; a_wr_addr = wa; a_wr_data = wd;
    a_rd_en = re; a_rd_addr = {r1, r0};
    step();
    a_wr_en = 1'b0; a_rd_en = 1'b0;
  endtask

  // No bypass and no zero entry: reads always see pre-edge contents.
  task automatic b_cycle(input logic we, input logic [2:0] wa, input logic [63:0] wd,
                         input logic re, input logic [11:0] ra);
    logic [255:0] e;
    e = '0;
    for (int i = 0; i < 4; i++) e[i*64 +: 64] = model_b[ra[i*3 +: 3]];
    if (re) exp_b_q.push_back(e);
    if (we) model_b[wa] = wd;
    b_wr_en = we; b_wr_addr = wa; b_wr_data = wd;
    b_rd_en = re; b_rd_addr = ra;
    step();
    b_wr_en = 1'b0; b_rd_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int a_len, b_len;
    logic a_done, b_done;
    logic [4:0] wa, r0, r1;
    logic [31:0] wd;
    logic we;

    for (int i = 0; i < 32; i++) model_a[i] = 32'h0;
    for (int i = 0; i < 8; i++) model_b[i] = 64'h0;
    a_rst = 1'b1; a_wr_en = 1'b0; a_rd_en = 1'b0; a_clr_req = 1'b0;
    a_wr_addr = '0; a_wr_data = '0; a_rd_addr = '0;
    b_rst = 1'b1; b_wr_en = 1'b0; b_rd_en = 1'b0; b_clr_req = 1'b0;
    b_wr_addr = '0; b_wr_data = '0; b_rd_addr = '0;

    // Reset state
    repeat (2) step();
    check_eq("a_reset_busy", a_busy, 1'b1);
    check_eq("a_reset_rd_valid", a_rd_valid, 1'b0);
    check_eq("a_reset_rd_data", a_rd_data, 64'h0);
    check_eq("b_reset_busy", b_busy, 1'b1);
    check_eq("b_reset_rd_data", b_rd_data, 256'h0);

    // Post-reset clear duration: DEPTH edges after rst falls
    a_rst = 1'b0; b_rst = 1'b0;
    a_len = 0; b_len = 0; a_done = 1'b0; b_done = 1'b0;
    for (int c = 1; c <= 100 && !(a_done && b_done); c++) begin
      step();
      if (!a_done) begin
        check_eq("a_clear_rd_valid", a_rd_valid, 1'b0);
        check_eq("a_clear_rd_data", a_rd_data, 64'h0);
        if (!a_busy) begin a_len = c; a_done = 1'b1; end
      end
      if (!b_done && !b_busy) begin b_len = c; b_done = 1'b1; end
    end
    check_eq("a_clear_len", a_len, 32);
    check_eq("b_clear_len", b_len, 8);

    // Write then read next cycle
    a_cycle(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd0);
    a_cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 5'd6);

    // Same-cycle bypass on both ports, then a plain read of the stored value
    a_cycle(1'b1, 5'd9, 32'h12345678, 1'b1, 5'd9, 5'd9);
    a_cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd9);
    b_cycle(1'b1, 3'd3, 64'h1111_1111_1111_1111, 1'b0, 12'h0);
    b_cycle(1'b1, 3'd3, 64'h2222_2222_2222_2222, 1'b1, {4{3'd3}});
    b_cycle(1'b0, 3'd0, 64'h0, 1'b1, {4{3'd3}});

    // Zero register
    a_cycle(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 5'd0);
    a_cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd0);
    a_cycle(1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 5'd5);
    a_cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd0);
    b_cycle(1'b1, 3'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 12'h0);
    b_cycle(1'b0, 3'd0, 64'h0, 1'b1, {4{3'd0}});

    // Wide variant: fill and read four distinct addresses per cycle
    for (int i = 0; i < 8; i++)
      b_cycle(1'b1, 3'(i), 64'(i) * 64'h0101_0101_0101_0101 + 64'hA5A5_0000_0000_005A, 1'b0, 12'h0);
    b_cycle(1'b0, 3'd0, 64'h0, 1'b1, {3'd7, 3'd6, 3'd4, 3'd1});
    b_cycle(1'b0, 3'd0, 64'h0, 1'b1, {3'd2, 3'd0, 3'd5, 3'd3});
    b_cycle(1'b0, 3'd0, 64'h0, 1'b1, {3'd5, 3'd2, 3'd5, 3'd2});

    // Random mixed traffic on A
    for (int n = 0; n < 24; n++) begin
      we = 1'($urandom); wa = 5'($urandom); wd = $urandom;
      r0 = 5'($urandom); r1 = (n % 4 == 0) ? wa : 5'($urandom);
      a_cycle(we, wa, wd, 1'b1, r0, r1);
    end

    // Fill A with addresses, request clear, reads refused while busy
    for (int i = 0; i < 32; i++) a_cycle(1'b1, 5'(i), 32'(i), 1'b0, 5'd0, 5'd0);
    a_clr_req = 1'b1;
    step();
    a_clr_req = 1'b0;
    check_eq("a_clrreq_busy", a_busy, 1'b1);
    a_rd_en = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      a_rd_addr = 10'($urandom);
      step();
      check_eq("a_clrreq_busy_hold", a_busy, 1'b1);
      check_eq("a_busy_rd_valid", a_rd_valid, 1'b0);
    end

    // Reset at clr_cnt == 10: clear restarts; a clr_req mid-clear is ignored
    a_rst = 1'b1;
    step();
    check_eq("a_midrst_busy", a_busy, 1'b1);
    check_eq("a_midrst_rd_valid", a_rd_valid, 1'b0);
    check_eq("a_midrst_rd_data", a_rd_data, 64'h0);
    a_rst = 1'b0;
    a_len = 0;
    for (int c = 1; c <= 100; c++) begin
      a_clr_req = (c == 5);
      step();
      check_eq("a_restart_rd_valid", a_rd_valid, 1'b0);
      if (!a_busy) begin a_len = c; break; end
    end
    a_clr_req = 1'b0; a_rd_en = 1'b0;
    check_eq("a_restart_len", a_len, 32);
    for (int i = 0; i < 32; i++) model_a[i] = 32'h0;
    for (int i = 0; i < 32; i++) a_cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'(i), 5'(31 - i));

    step();
    check_eq("a_queue_drained", exp_a_q.size(), 0);
    check_eq("b_queue_drained", exp_b_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
